// File: rtl/mc_main_ctrl_if.sv
// rtl/mc_main_ctrl_if.sv - control bus between multicycle MIPS datapath and its main control FSM
//
// Signals:
//   op[5:0]        IR[31:26] opcode seen by the controller
//   zero           ALU zero flag
//   mem_ready      memory completes the current access this cycle
//   iord           memory address select (0=PC, 1=ALUOut)
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       IR load enable
//   reg_dst        write register select (0=rt, 1=rd)
//   mem_to_reg     write data select (0=ALUOut, 1=MDR)
//   reg_write      register file write enable
//   alu_src_a      ALU A select (0=PC, 1=A)
//   alu_src_b[1:0] ALU B select (00=B, 01=4, 10=SignImm, 11=SignImm<<2)
//   alu_op[1:0]    00=add, 01=sub, 10=funct decode
//   pc_src[1:0]    00=ALUResult, 01=ALUOut, 10=jump target
//   pc_write       PC load enable, branch condition already folded in
//   mem_timeout    sticky memory wait timeout
//   state_out[3:0] current FSM state for debug
// Modports: master = datapath side, slave = controller side.

interface mc_main_ctrl_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       mem_timeout;
    logic [3:0] state_out;

    modport master (
        output op, zero, mem_ready,
        input  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_write,
               mem_timeout, state_out
    );

    modport slave (
        input  op, zero, mem_ready,
        output iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_write,
               mem_timeout, state_out
    );
endinterface

// File: rtl/mc_main_ctrl.sv
// rtl/mc_main_ctrl.sv - multicycle MIPS main control FSM (lw, sw, R-type, beq, addi, j)
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; also forces every output to 0 while high
//   bus    mc_main_ctrl_if.slave: op/zero/mem_ready in, all mux selects,
//          write enables, mem_timeout and state_out out
// Parameters:
//   MEM_WAIT_MAX  cycles of mem_ready=0 before mem_timeout is raised (0 = never)
// Build option:
//   MC_ILLEGAL_TRAP_EN  when defined, an unrecognised opcode parks the FSM in
//                       TRAP (state 12) until reset; otherwise it is a NOP.

module mc_main_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          reset,
    mc_main_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int              CNT_W      = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MEM_WAIT_MAX);
    localparam bit              TIMEOUT_EN = (MEM_WAIT_MAX != 0);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_timeout;
    logic             w_waiting;

    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_src;
    logic       w_pc_write;

    // Only the three memory-access states stall on mem_ready.
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // Saturating increment: the FSM keeps waiting after a timeout.
    assign w_cnt_inc = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_waiting && !bus.mem_ready) begin
                r_wait_cnt <= w_cnt_inc;
                if (TIMEOUT_EN && (w_cnt_inc == CNT_MAX)) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      w_next = S_TRAP;
`else
                    default:      w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: w_next = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) w_next = S_MEMWB;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) w_next = S_FETCH;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:   w_next = S_TRAP;
`endif
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_pc_src     = 2'b00;
        w_pc_write   = 1'b0;
        case (r_state)
            S_FETCH: begin
                // PC+4 and IR load commit only on the cycle the fetch completes.
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                // Branch target precompute into ALUOut.
                w_alu_src_b = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b01;
                w_pc_src    = 2'b01;
                w_pc_write  = bus.zero;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            S_JUMP: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset masks the Moore decode so no enable can fire while reset is held.
    assign bus.iord        = w_iord       & ~reset;
    assign bus.mem_read    = w_mem_read   & ~reset;
    assign bus.mem_write   = w_mem_write  & ~reset;
    assign bus.ir_write    = w_ir_write   & ~reset;
    assign bus.reg_dst     = w_reg_dst    & ~reset;
    assign bus.mem_to_reg  = w_mem_to_reg & ~reset;
    assign bus.reg_write   = w_reg_write  & ~reset;
    assign bus.alu_src_a   = w_alu_src_a  & ~reset;
    assign bus.alu_src_b   = reset ? 2'b00 : w_alu_src_b;
    assign bus.alu_op      = reset ? 2'b00 : w_alu_op;
    assign bus.pc_src      = reset ? 2'b00 : w_pc_src;
    assign bus.pc_write    = w_pc_write   & ~reset;
    assign bus.mem_timeout = r_timeout    & ~reset;
    assign bus.state_out   = reset ? 4'd0 : r_state;

endmodule
